// File: rtl/health_shield_tracker_pkg.sv
// Shared constants for the combat slice: stun codes, round state and winner encodings.
// Hit detection and the gameplay controllers import these same encodings.
package health_shield_tracker_pkg;

  typedef enum logic [1:0] {
    STUN_NONE  = 2'b00,
    STUN_HIT   = 2'b01,
    STUN_BLOCK = 2'b10,
    STUN_RSVD  = 2'b11
  } stun_e;

  typedef enum logic [1:0] {
    S_PLAY = 2'b00,
    S_KO   = 2'b01,
    S_DONE = 2'b10
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/health_shield_tracker_vitals.sv
// Per-player health/shield bookkeeping: stun edge detect, damage, block and shield regen.
// Next-state values are exported so the round FSM can resolve KO/time-out on the same edge.
module player_vitals
  import health_shield_tracker_pkg::*;
#(
  parameter int unsigned MAX_HEALTH          = 3,
  parameter int unsigned MAX_SHIELD          = 3,
  parameter int unsigned SHIELD_REGEN_FRAMES = 180
) (
  input  logic       logic_clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       reload,
  input  logic [1:0] stunmode,
  output logic [2:0] health,
  output logic [2:0] shield,
  output logic [2:0] health_nxt,
  output logic [2:0] shield_nxt
);

  localparam int unsigned    RW         = cnt_width(SHIELD_REGEN_FRAMES);
  localparam logic [2:0]     H_INIT     = 3'(MAX_HEALTH);
  localparam logic [2:0]     S_MAX      = 3'(MAX_SHIELD);
  localparam logic [RW-1:0]  REGEN_LAST = RW'(SHIELD_REGEN_FRAMES - 1);

  logic [1:0]    prev_stun;
  logic [RW-1:0] regen_cnt;
  logic [RW-1:0] regen_nxt;
  logic          stun_event;
  logic          hit_ev;
  logic          block_ev;

  always_comb begin
    stun_event = (stunmode != STUN_NONE) && (stunmode != prev_stun);
    hit_ev     = enable && stun_event && (stunmode == STUN_HIT);
    block_ev   = enable && stun_event && (stunmode == STUN_BLOCK);
    health_nxt = health;
    shield_nxt = shield;
    regen_nxt  = regen_cnt;

    // A block with no shield left chips health like a hit.
    if (hit_ev || (block_ev && shield == '0))
      health_nxt = (health != '0) ? health - 3'd1 : '0;

    if (block_ev) begin
      if (shield != '0)
        shield_nxt = shield - 3'd1;
      regen_nxt = '0;
    end else if (enable) begin
      if (shield < S_MAX) begin
        if (regen_cnt == REGEN_LAST) begin
          shield_nxt = shield + 3'd1;
          regen_nxt  = '0;
        end else begin
          regen_nxt = regen_cnt + 1'b1;
        end
      end else begin
        regen_nxt = '0;
      end
    end
  end

  always_ff @(posedge logic_clk) begin
    if (!reset || reload) begin
      health    <= H_INIT;
      shield    <= S_MAX;
      regen_cnt <= '0;
      prev_stun <= STUN_NONE;
    end else begin
      health    <= health_nxt;
      shield    <= shield_nxt;
      regen_cnt <= regen_nxt;
      prev_stun <= stunmode;
    end
  end

endmodule

// File: rtl/health_shield_tracker.sv
// Round lifecycle for a two-player match: vitals per player, round timer,
// KO/time-out resolution and the controller freeze, all on the 60 Hz frame clock.
module health_shield_tracker
  import health_shield_tracker_pkg::*;
#(
  parameter int unsigned MAX_HEALTH          = 3,
  parameter int unsigned MAX_SHIELD          = 3,
  parameter int unsigned SHIELD_REGEN_FRAMES = 180,
  parameter int unsigned FRAMES_PER_SEC      = 60,
  parameter int unsigned ROUND_SECONDS       = 99,
  parameter int unsigned KO_HOLD_FRAMES      = 120
) (
  input  logic       logic_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] stunmode1,
  input  logic [1:0] stunmode2,
  output logic [2:0] health1,
  output logic [2:0] health2,
  output logic [2:0] shield1,
  output logic [2:0] shield2,
  output logic [6:0] time_left,
  output logic [1:0] game_state,
  output logic [1:0] winner,
  output logic       freeze
);

  localparam int unsigned   FW         = cnt_width(FRAMES_PER_SEC);
  localparam int unsigned   KW         = cnt_width(KO_HOLD_FRAMES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [KW-1:0] KO_LAST    = KW'(KO_HOLD_FRAMES - 1);
  localparam logic [6:0]    T_INIT     = 7'(ROUND_SECONDS);

  game_state_e   state, state_nxt;
  winner_e       win_q, win_nxt;
  logic [FW-1:0] frame_cnt;
  logic [KW-1:0] ko_cnt;
  logic [6:0]    time_nxt;
  logic [2:0]    h1_nxt, h2_nxt, s1_nxt, s2_nxt;
  logic          play, reload, frame_wrap;

  assign play   = (state == S_PLAY);
  assign reload = (state == S_DONE) && start;

  player_vitals #(
    .MAX_HEALTH         (MAX_HEALTH),
    .MAX_SHIELD         (MAX_SHIELD),
    .SHIELD_REGEN_FRAMES(SHIELD_REGEN_FRAMES)
  ) u_p1 (
    .logic_clk (logic_clk),
    .reset     (reset),
    .enable    (play),
    .reload    (reload),
    .stunmode  (stunmode1),
    .health    (health1),
    .shield    (shield1),
    .health_nxt(h1_nxt),
    .shield_nxt(s1_nxt)
  );

  player_vitals #(
    .MAX_HEALTH         (MAX_HEALTH),
    .MAX_SHIELD         (MAX_SHIELD),
    .SHIELD_REGEN_FRAMES(SHIELD_REGEN_FRAMES)
  ) u_p2 (
    .logic_clk (logic_clk),
    .reset     (reset),
    .enable    (play),
    .reload    (reload),
    .stunmode  (stunmode2),
    .health    (health2),
    .shield    (shield2),
    .health_nxt(h2_nxt),
    .shield_nxt(s2_nxt)
  );

  always_comb begin
    frame_wrap = play && (frame_cnt == FRAME_LAST);
    time_nxt   = (frame_wrap && time_left != '0) ? time_left - 7'd1 : time_left;
  end

  always_ff @(posedge logic_clk) begin
    if (!reset || reload) begin
      frame_cnt <= '0;
      time_left <= T_INIT;
      ko_cnt    <= '0;
    end else begin
      if (play)
        frame_cnt <= frame_wrap ? '0 : frame_cnt + 1'b1;
      time_left <= time_nxt;
      ko_cnt    <= (state == S_KO && ko_cnt != KO_LAST) ? ko_cnt + 1'b1 : '0;
    end
  end

  // KO is checked before time-out so a simultaneous expiry resolves as a KO.
  always_comb begin
    state_nxt = state;
    win_nxt   = win_q;
    case (state)
      S_PLAY: begin
        if (h1_nxt == '0 || h2_nxt == '0) begin
          state_nxt = S_KO;
          if (h1_nxt == '0 && h2_nxt == '0) win_nxt = WIN_DRAW;
          else if (h2_nxt == '0)            win_nxt = WIN_P1;
          else                              win_nxt = WIN_P2;
        end else if (time_nxt == '0) begin
          state_nxt = S_KO;
          if (h1_nxt > h2_nxt)      win_nxt = WIN_P1;
          else if (h1_nxt < h2_nxt) win_nxt = WIN_P2;
          else if (s1_nxt > s2_nxt) win_nxt = WIN_P1;
          else if (s1_nxt < s2_nxt) win_nxt = WIN_P2;
          else                      win_nxt = WIN_DRAW;
        end
      end
      S_KO: begin
        if (ko_cnt == KO_LAST)
          state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_nxt = S_PLAY;
          win_nxt   = WIN_NONE;
        end
      end
      default: begin
        state_nxt = S_PLAY;
        win_nxt   = WIN_NONE;
      end
    endcase
  end

  always_ff @(posedge logic_clk) begin
    if (!reset) begin
      state <= S_PLAY;
      win_q <= WIN_NONE;
    end else begin
      state <= state_nxt;
      win_q <= win_nxt;
    end
  end

  assign game_state = state;
  assign winner     = win_q;
  assign freeze     = (state != S_PLAY);

endmodule
